// File: rtl/fm7_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, sub-CPU and loader share the
// remaining cycles round-robin; read data returns in order through a latency-matched tag pipeline.
module fm7_vram_arbiter #(
   parameter int AW          = 16,
   parameter int DW          = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic [DW-1:0] disp_data,
   output logic          disp_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic [DW-1:0] ldr_rdata,
   output logic          ldr_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   // Handshake: cpu/ldr hold req (with we/addr/wdata) until a one-cycle ack; inputs are taken
   // only in the grant cycle, and req still high the cycle after ack starts a new access.
   // disp_req is a fire-and-forget pulse answered by a disp_valid pulse RAM_LATENCY+2 cycles later.

   localparam logic [1:0] OWN_DISP = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_LDR  = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [1:0] owner;
      logic       we;
   } tag_t;

   tag_t tag_q [0:RAM_LATENCY];
   tag_t tag_new;

   logic rr_last_cpu;
   logic cpu_out, ldr_out;
   logic cpu_elig, ldr_elig;
   logic grant_disp, grant_cpu, grant_ldr;
   logic wr_done, rd_done;

   always_comb begin
      cpu_elig   = cpu_req & ~cpu_out;
      ldr_elig   = ldr_req & ~ldr_out;
      grant_disp = disp_req;
      grant_cpu  = 1'b0;
      grant_ldr  = 1'b0;
      tag_new    = '0;
      if (!disp_req) begin
         // When both are eligible, serve the one that was not served last.
         grant_cpu = cpu_elig & (~ldr_elig | ~rr_last_cpu);
         grant_ldr = ldr_elig & (~cpu_elig | rr_last_cpu);
      end
      if (grant_disp) begin
         tag_new = '{valid: 1'b1, owner: OWN_DISP, we: 1'b0};
      end else if (grant_cpu) begin
         tag_new = '{valid: 1'b1, owner: OWN_CPU, we: cpu_we};
      end else if (grant_ldr) begin
         tag_new = '{valid: 1'b1, owner: OWN_LDR, we: ldr_we};
      end
   end

   // Writes complete one cycle after the strobe; reads when the tag reaches the RAM latency.
   always_comb begin
      wr_done = tag_q[0].valid & tag_q[0].we;
      rd_done = tag_q[RAM_LATENCY].valid & ~tag_q[RAM_LATENCY].we;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ram_addr    <= '0;
         ram_we      <= 1'b0;
         ram_wdata   <= '0;
         disp_data   <= '0;
         disp_valid  <= 1'b0;
         cpu_rdata   <= '0;
         cpu_ack     <= 1'b0;
         ldr_rdata   <= '0;
         ldr_ack     <= 1'b0;
         rr_last_cpu <= 1'b0;
         cpu_out     <= 1'b0;
         ldr_out     <= 1'b0;
         for (int k = 0; k <= RAM_LATENCY; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         ram_we <= 1'b0;
         if (grant_disp) begin
            ram_addr <= disp_addr;
         end else if (grant_cpu) begin
            ram_addr <= cpu_addr;
            ram_we   <= cpu_we;
            if (cpu_we) ram_wdata <= cpu_wdata;
         end else if (grant_ldr) begin
            ram_addr <= ldr_addr;
            ram_we   <= ldr_we;
            if (ldr_we) ram_wdata <= ldr_wdata;
         end

         tag_q[0] <= tag_new;
         for (int k = 1; k <= RAM_LATENCY; k++) begin
            tag_q[k] <= tag_q[k-1];
         end

         if (grant_cpu)      rr_last_cpu <= 1'b1;
         else if (grant_ldr) rr_last_cpu <= 1'b0;

         cpu_out <= grant_cpu | (cpu_out & ~cpu_ack);
         ldr_out <= grant_ldr | (ldr_out & ~ldr_ack);

         disp_valid <= rd_done && (tag_q[RAM_LATENCY].owner == OWN_DISP);
         cpu_ack    <= (wr_done && (tag_q[0].owner == OWN_CPU)) ||
                       (rd_done && (tag_q[RAM_LATENCY].owner == OWN_CPU));
         ldr_ack    <= (wr_done && (tag_q[0].owner == OWN_LDR)) ||
                       (rd_done && (tag_q[RAM_LATENCY].owner == OWN_LDR));

         if (rd_done) begin
            case (tag_q[RAM_LATENCY].owner)
               OWN_DISP: disp_data <= ram_rdata;
               OWN_CPU:  cpu_rdata <= ram_rdata;
               OWN_LDR:  ldr_rdata <= ram_rdata;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fm7_vram_arbiter.sv
// Bench for fm7_vram_arbiter: a RAM_LATENCY=1 instance with a scoreboard and vector table,
// plus a RAM_LATENCY=3 instance exercised by a short timing sequence.
module tb_fm7_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A (RAM_LATENCY=1)
   logic        disp_req, cpu_req, cpu_we, ldr_req, ldr_we;
   logic [15:0] disp_addr, cpu_addr, ldr_addr;
   logic [7:0]  cpu_wdata, ldr_wdata;
   logic [7:0]  disp_data, cpu_rdata, ldr_rdata, ram_wdata, ram_rdata;
   logic        disp_valid, cpu_ack, ldr_ack, ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  mem_a [0:65535];

   fm7_vram_arbiter #(.AW(16), .DW(8), .RAM_LATENCY(1)) dut (
      .clk(clk), .reset_n(reset_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always @(posedge clk) begin
      if (ram_we) mem_a[ram_addr] <= ram_wdata;
      ram_rdata <= mem_a[ram_addr];
   end

   // Instance B (RAM_LATENCY=3)
   logic        b_disp_req, b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we;
   logic [15:0] b_disp_addr, b_cpu_addr, b_ldr_addr;
   logic [7:0]  b_cpu_wdata, b_ldr_wdata;
   logic [7:0]  b_disp_data, b_cpu_rdata, b_ldr_rdata, b_ram_wdata, b_ram_rdata;
   logic        b_disp_valid, b_cpu_ack, b_ldr_ack, b_ram_we;
   logic [15:0] b_ram_addr;
   logic [7:0]  mem_b [0:65535];
   logic [7:0]  b_st1, b_st2;

   fm7_vram_arbiter #(.AW(16), .DW(8), .RAM_LATENCY(3)) dut_l3 (
      .clk(clk), .reset_n(reset_n),
      .disp_req(b_disp_req), .disp_addr(b_disp_addr), .disp_data(b_disp_data), .disp_valid(b_disp_valid),
      .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
      .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
      .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
      .ldr_rdata(b_ldr_rdata), .ldr_ack(b_ldr_ack),
      .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
   );

   always @(posedge clk) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
      b_st1       <= mem_b[b_ram_addr];
      b_st2       <= b_st1;
      b_ram_rdata <= b_st2;
   end

   // Scoreboard: {is_read, data}; write entries require rdata to stay unchanged.
   logic [7:0] disp_q [$];
   logic [8:0] cpu_q  [$];
   logic [8:0] ldr_q  [$];
   logic [7:0] cpu_prev = 8'h00;
   logic [7:0] ldr_prev = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (disp_valid) begin
         if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
         else check("disp_data", 32'(disp_data), 32'(disp_q.pop_front()));
      end
      if (cpu_ack) begin
         if (cpu_q.size() == 0) check("cpu_ack_unexpected", 1, 0);
         else begin
            e = cpu_q.pop_front();
            if (e[8]) check("cpu_rdata", 32'(cpu_rdata), 32'(e[7:0]));
            else      check("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_prev));
         end
      end
      if (ldr_ack) begin
         if (ldr_q.size() == 0) check("ldr_ack_unexpected", 1, 0);
         else begin
            e = ldr_q.pop_front();
            if (e[8]) check("ldr_rdata", 32'(ldr_rdata), 32'(e[7:0]));
            else      check("ldr_rdata_hold", 32'(ldr_rdata), 32'(ldr_prev));
         end
      end
      cpu_prev = cpu_rdata;
      ldr_prev = ldr_rdata;
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one cpu (port=0) or ldr (port=1) access to completion, bounded.
   task automatic access(input bit port, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp);
      int n = 0;
      bit seen = 0;
      if (!port) begin
         cpu_q.push_back({~we, exp});
         cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      end else begin
         ldr_q.push_back({~we, exp});
         ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
      end
      while (!seen && n < 20) begin
         @(negedge clk);
         seen = port ? ldr_ack : cpu_ack;
         n++;
      end
      if (!seen) check("access_timeout", 0, 1);
      next_cycle();
      if (!port) cpu_req = 0; else ldr_req = 0;
   endtask

   // Holds req and checks successive acks are exactly 4 cycles apart.
   task automatic rr_port(input bit port, output int first);
      int last = 0;
      int n;
      bit seen;
      first = 0;
      for (int k = 0; k < 3; k++) begin
         n = 0; seen = 0;
         while (!seen && n < 20) begin
            @(negedge clk);
            seen = port ? ldr_ack : cpu_ack;
            n++;
         end
         if (!seen) check("rr_timeout", 0, 1);
         if (k == 0) first = cyc;
         else check(port ? "rr_ldr_interval" : "rr_cpu_interval", 32'(cyc - last), 4);
         last = cyc;
      end
      next_cycle();
      if (!port) cpu_req = 0; else ldr_req = 0;
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [15:0] addr;
      logic [7:0]  data;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   cf, lf, d;
      bit   ack_seen;

      tbl[0]  = '{0, 1, 16'hFFFF, 8'hFF};
      tbl[1]  = '{1, 1, 16'h0000, 8'h5C};
      tbl[2]  = '{0, 1, 16'h8001, 8'h3A};
      tbl[3]  = '{1, 1, 16'hBFFF, 8'hC7};
      tbl[4]  = '{1, 0, 16'hFFFF, 8'hFF};
      tbl[5]  = '{0, 0, 16'h0000, 8'h5C};
      tbl[6]  = '{0, 0, 16'hBFFF, 8'hC7};
      tbl[7]  = '{1, 0, 16'h8001, 8'h3A};
      tbl[8]  = '{0, 1, 16'h8001, 8'h00};
      tbl[9]  = '{1, 0, 16'h8001, 8'h00};
      tbl[10] = '{1, 1, 16'hFFFF, 8'h96};
      tbl[11] = '{0, 0, 16'hFFFF, 8'h96};

      reset_n = 0;
      disp_req = 0; disp_addr = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
      b_disp_req = 0; b_disp_addr = 0;
      b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
      b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_ram", 32'({ram_addr, ram_we, ram_wdata}), 0);
      check("reset_strobes", 32'({disp_valid, cpu_ack, ldr_ack}), 0);
      check("reset_rdata", 32'({disp_data, cpu_rdata, ldr_rdata}), 0);
      next_cycle();
      reset_n = 1;

      // Single CPU write then read-back with exact timing
      next_cycle();
      cpu_q.push_back({1'b0, 8'h00});
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'h4000; cpu_wdata = 8'hA5;
      @(negedge clk); check("wr_n_ram_we", 32'(ram_we), 0);
      next_cycle();
      @(negedge clk);
      check("wr_n1_ram_we", 32'(ram_we), 1);
      check("wr_n1_ram_addr", 32'(ram_addr), 'h4000);
      check("wr_n1_ram_wdata", 32'(ram_wdata), 'hA5);
      check("wr_n1_ack", 32'(cpu_ack), 0);
      next_cycle();
      @(negedge clk);
      check("wr_n2_ack", 32'(cpu_ack), 1);
      check("wr_n2_ram_we", 32'(ram_we), 0);
      next_cycle();
      cpu_q.push_back({1'b1, 8'hA5});
      cpu_we = 0; cpu_addr = 16'h4000; cpu_wdata = 8'h00;
      next_cycle();
      @(negedge clk);
      check("rd_g1_ram_addr", 32'(ram_addr), 'h4000);
      check("rd_g1_ram_we", 32'(ram_we), 0);
      next_cycle();
      @(negedge clk); check("rd_g2_ack", 32'(cpu_ack), 0);
      next_cycle();
      @(negedge clk); check("rd_g3_ack", 32'(cpu_ack), 1);
      next_cycle();
      cpu_req = 0;

      // Vector table through both ports
      for (int i = 0; i < 12; i++) begin
         access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].data);
      end

      // Display priority over a simultaneous CPU read
      access(0, 1, 16'h0010, 8'h3C, 8'h00);
      access(0, 1, 16'h0020, 8'h7E, 8'h00);
      disp_q.push_back(8'h3C);
      cpu_q.push_back({1'b1, 8'h7E});
      disp_req = 1; disp_addr = 16'h0010;
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
      next_cycle();
      disp_req = 0;
      @(negedge clk); check("prio_n1_addr", 32'(ram_addr), 'h0010);
      next_cycle();
      @(negedge clk);
      check("prio_n2_addr", 32'(ram_addr), 'h0020);
      check("prio_n2_valid", 32'(disp_valid), 0);
      next_cycle();
      @(negedge clk);
      check("prio_n3_valid", 32'(disp_valid), 1);
      check("prio_n3_ack", 32'(cpu_ack), 0);
      next_cycle();
      @(negedge clk); check("prio_n4_ack", 32'(cpu_ack), 1);
      next_cycle();
      cpu_req = 0;

      // Display burst of 4 while a CPU read is pending
      for (int i = 0; i < 4; i++) access(0, 1, 16'(i), 8'(8'h11 * (i + 1)), 8'h00);
      access(0, 1, 16'h0030, 8'hC3, 8'h00);
      cpu_q.push_back({1'b1, 8'hC3});
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030;
      for (int i = 0; i < 4; i++) begin
         disp_req = 1; disp_addr = 16'(i);
         disp_q.push_back(8'(8'h11 * (i + 1)));
         @(negedge clk);
         if (i > 0) check("burst_addr", 32'(ram_addr), 32'(i - 1));
         if (i == 3) check("burst_valid0", 32'(disp_valid), 1);
         next_cycle();
      end
      disp_req = 0;
      @(negedge clk);
      check("burst_b4_addr", 32'(ram_addr), 'h0003);
      check("burst_valid1", 32'(disp_valid), 1);
      next_cycle();
      @(negedge clk);
      check("burst_cpu_addr", 32'(ram_addr), 'h0030);
      check("burst_valid2", 32'(disp_valid), 1);
      next_cycle();
      @(negedge clk); check("burst_valid3", 32'(disp_valid), 1);
      next_cycle();
      @(negedge clk);
      check("burst_cpu_ack", 32'(cpu_ack), 1);
      check("burst_valid_end", 32'(disp_valid), 0);
      next_cycle();
      cpu_req = 0;

      // Round-robin with both requests held
      access(0, 1, 16'h1000, 8'hAA, 8'h00);
      access(1, 1, 16'h2000, 8'hBB, 8'h00);
      for (int k = 0; k < 3; k++) begin
         cpu_q.push_back({1'b1, 8'hAA});
         ldr_q.push_back({1'b1, 8'hBB});
      end
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1000;
      ldr_req = 1; ldr_we = 0; ldr_addr = 16'h2000;
      fork
         rr_port(0, cf);
         rr_port(1, lf);
      join
      d = (cf > lf) ? cf - lf : lf - cf;
      check("rr_alternate", 32'(d), 1);

      // Reset during an in-flight CPU read
      next_cycle();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000;
      next_cycle();
      reset_n = 0;
      next_cycle();
      reset_n = 1;
      cpu_req = 0;
      @(negedge clk);
      check("rst_mid_ram", 32'({ram_addr, ram_we, ram_wdata}), 0);
      check("rst_mid_rdata", 32'({disp_data, cpu_rdata, ldr_rdata}), 0);
      ack_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ack_seen = ack_seen | cpu_ack;
         next_cycle();
      end
      check("rst_mid_no_ack", 32'(ack_seen), 0);
      access(0, 0, 16'h4000, 8'h00, 8'hA5);
      access(0, 1, 16'h4001, 8'h69, 8'h00);
      access(1, 0, 16'h4001, 8'h00, 8'h69);

      // RAM_LATENCY=3 instance: write ack at grant+2, display valid at N+5
      b_cpu_req = 1; b_cpu_we = 1; b_cpu_addr = 16'h0100; b_cpu_wdata = 8'h5A;
      next_cycle();
      @(negedge clk); check("l3_ram_we", 32'({b_ram_we, b_ram_addr, b_ram_wdata}), 32'({1'b1, 16'h0100, 8'h5A}));
      next_cycle();
      @(negedge clk); check("l3_wr_ack", 32'(b_cpu_ack), 1);
      next_cycle();
      b_cpu_req = 0; b_cpu_we = 0;
      b_disp_req = 1; b_disp_addr = 16'h0100;
      next_cycle();
      b_disp_req = 0;
      next_cycle();
      next_cycle();
      next_cycle();
      @(negedge clk); check("l3_valid_n4", 32'(b_disp_valid), 0);
      next_cycle();
      @(negedge clk);
      check("l3_valid_n5", 32'(b_disp_valid), 1);
      check("l3_disp_data", 32'(b_disp_data), 'h5A);
      next_cycle();
      @(negedge clk); check("l3_valid_n6", 32'(b_disp_valid), 0);

      repeat (4) next_cycle();
      check("sb_drain", 32'(disp_q.size() + cpu_q.size() + ldr_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fm7_vram_arbiter.md
Name: fm7_vram_arbiter

Overview:
- Shares the single-port video RAM between three requesters: display scan-out fetch, sub-CPU bus, and the HPS loader/debug port.
- Sits between the video timing/fetch logic and the VRAM instance inside the fm7 core.
- Display fetch has absolute priority. Sub-CPU and loader are served round-robin from the remaining cycles.
- Read results return in order through a tagged pipeline matched to the RAM latency.

Parameters:
AW, 16, VRAM address width (48 KB = 3 planes x 16 KB fits in 16 bits)
DW, 8, data width
RAM_LATENCY, 1, cycles from address presented at RAM to ram_rdata valid; legal 1..3

Ports:
clk  in  1  system clock (clk_sys domain)
reset_n  in  1  reset, synchronous, active-low
disp_req  in  1  one-cycle pulse: display fetch request
disp_addr  in  AW  fetch address, valid with disp_req
disp_data  out  DW  fetched byte
disp_valid  out  1  one-cycle pulse: disp_data valid
cpu_req  in  1  sub-CPU request, level, held until cpu_ack
cpu_we  in  1  1 = write
cpu_addr  in  AW  address
cpu_wdata  in  DW  write data
cpu_rdata  out  DW  read data, valid with cpu_ack on reads
cpu_ack  out  1  one-cycle pulse: access complete
ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same directions/widths/meanings as the cpu_* ports, for the loader
ram_addr  out  AW  VRAM address
ram_we  out  1  VRAM write strobe
ram_wdata  out  DW  VRAM write data
ram_rdata  in  DW  VRAM read data

Behaviour:
- Arbitration per cycle N; at most one grant per cycle.
  - Priority: disp_req, then the eligible cpu/ldr port by round-robin.
  - Grant registers ram_addr/ram_we/ram_wdata, visible in cycle N+1.
- Round-robin:
  - rr bit records last-served of cpu/ldr; after reset, cpu is favoured first.
  - When both are eligible, grant the one not last served.
  - rr updates only on cpu/ldr grants.
- Eligibility:
  - A port is eligible if req=1 and it has no outstanding access.
  - Outstanding is set at grant and cleared in its ack cycle.
  - req is re-sampled from the cycle after ack; req still high then counts as a new access (back-to-back allowed).
- Display is never blocked.
  - disp_req on consecutive cycles is legal and pipelined.
  - CPU/loader wait while display pulses are contiguous; the timing generator guarantees gaps.
- Tag pipeline: depth RAM_LATENCY+1, entries {valid, owner[1:0], we}.
  - Read data is captured from ram_rdata at cycle N+1+RAM_LATENCY into a register.
  - Registered data is presented with the strobe at N+2+RAM_LATENCY.
  - Default RAM_LATENCY=1: disp_req at N gives disp_valid at N+3.
- Writes:
  - ram_we=1 for exactly the one cycle N+1.
  - Ack at N+2.
  - rdata outputs unchanged on write acks.
- Idle cycles: ram_we=0; ram_addr/ram_wdata hold last value.
- Reads never disturb the pending write data of another port.
- Strobes in-order per owner; different owners may ack in the same cycle (display read from N, CPU write from N+1).
- Reset (reset_n=0 at a clock edge):
  - All outputs 0 (ram_addr, ram_wdata, rdata/data regs, strobes).
  - Tag pipeline and outstanding flags cleared; rr favours cpu.
  - Accesses in flight when reset is applied are dropped with no ack/valid.
  - The first grant is possible in the cycle after reset_n returns high.
- Port inputs (addr/we/wdata) are sampled only in the grant cycle; changes afterward have no effect.

Test Plan:
- Single CPU write: cpu_req=1, we=1, addr=16'h4000, wdata=8'hA5 at N -> ram_we=1, ram_addr=16'h4000, ram_wdata=8'hA5 in N+1 only; cpu_ack at N+2. Then a CPU read of 16'h4000 returns cpu_rdata=8'hA5 with cpu_ack 3 cycles after its grant.
- Display priority: disp_req(16'h0010) and cpu_req read(16'h0020) both at N -> ram_addr=16'h0010 at N+1 and 16'h0020 at N+2; disp_valid at N+3, cpu_ack at N+4, data correct.
- Round-robin: cpu_req and ldr_req held high continuously, no display -> grants alternate cpu, ldr, cpu, ldr. Each port is granted at most once until its ack, then regranted the cycle after ack.
- Display burst: disp_req for 4 consecutive cycles with addresses 0..3 while cpu_req is pending -> 4 disp_valid pulses, in order, on consecutive cycles; CPU granted in the cycle after the burst.
- Reset mid-operation: CPU read granted at N, reset_n=0 at N+1 for 1 cycle -> no cpu_ack at any cycle; all outputs 0; a new cpu_req after reset completes normally.
- RAM_LATENCY=3 build: disp_req at N -> disp_valid at N+5 with the correct byte; a write ack still arrives at grant+2.
